// File: rtl/mem_bus_ctrl_pkg.sv
// Shared definitions for mem_bus_ctrl: FSM encodings, stall-protocol values,
// stall-vector bit indices and the zero word.
package mem_bus_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_IF_BUSY  = 3'd1,
    S_MEM_BUSY = 3'd2,
    S_IF_HOLD  = 3'd3,
    S_MEM_HOLD = 3'd4
  } state_t;

  localparam logic        Stop      = 1'b1;
  localparam logic        NoStop    = 1'b0;
  localparam int          STALL_IF  = 1;
  localparam int          STALL_MEM = 4;
  localparam logic [31:0] ZeroWord  = 32'h0000_0000;

  // Stall request for a port: asserted while it wants the bus and has no result held.
  function automatic logic port_stallreq(input logic ce, input logic holding);
    return (ce && !holding) ? Stop : NoStop;
  endfunction

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// Pipeline-side ports, stall/flush protocol and Wishbone-style bus of mem_bus_ctrl.
// Handshake: a bus cycle is valid while bus_cyc_o=1 (STB==CYC); request fields are
// held stable until bus_ack_i=1 is sampled on a rising clk, which completes it.
interface mem_bus_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import mem_bus_ctrl_pkg::*;

  logic [5:0]        stall;
  logic              flush;
  logic              if_ce;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              stallreq_pc;
  logic              mem_ce;
  logic              mem_we;
  logic [3:0]        mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              stallreq_mem;
  logic              bus_cyc_o;
  logic              bus_we_o;
  logic [3:0]        bus_sel_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [DATA_W-1:0] bus_wdata_o;
  logic [DATA_W-1:0] bus_rdata_i;
  logic              bus_ack_i;
  logic              bus_err_o;
  state_t            dbg_state;

  modport master (
    input  stall, flush, if_ce, if_addr, mem_ce, mem_we, mem_sel, mem_addr,
           mem_wdata, bus_rdata_i, bus_ack_i,
    output if_rdata, stallreq_pc, mem_rdata, stallreq_mem, bus_cyc_o, bus_we_o,
           bus_sel_o, bus_addr_o, bus_wdata_o, bus_err_o, dbg_state
  );

  modport slave (
    output stall, flush, if_ce, if_addr, mem_ce, mem_we, mem_sel, mem_addr,
           mem_wdata, bus_rdata_i, bus_ack_i,
    input  if_rdata, stallreq_pc, mem_rdata, stallreq_mem, bus_cyc_o, bus_we_o,
           bus_sel_o, bus_addr_o, bus_wdata_o, bus_err_o, dbg_state
  );

endinterface

// File: rtl/mem_bus_ctrl_bus_port_mux.sv
// Picks the IF or MEM request fields to launch onto the bus; purely combinational.
module bus_port_mux #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              i_sel_mem,
  input  logic [ADDR_W-1:0] i_if_addr,
  input  logic              i_mem_we,
  input  logic [3:0]        i_mem_sel,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic              o_we,
  output logic [3:0]        o_sel,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wdata
);
  import mem_bus_ctrl_pkg::*;

  always_comb begin
    // A fetch is always a full-word read.
    o_we    = 1'b0;
    o_sel   = 4'hF;
    o_addr  = i_if_addr;
    o_wdata = DATA_W'(ZeroWord);
    if (i_sel_mem) begin
      o_we    = i_mem_we;
      o_sel   = i_mem_sel;
      o_addr  = i_mem_addr;
      o_wdata = i_mem_wdata;
    end
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Single-master bus controller serving the IF and MEM ports of the pipeline.
// Optional watchdog enabled by defining BUS_TIMEOUT_EN.
module mem_bus_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic           clk,
  input  logic           rst,
  mem_bus_ctrl_if.master bus
);
  import mem_bus_ctrl_pkg::*;

  state_t            r_state, w_next;
  logic              r_cyc, r_we, r_discard;
  logic [3:0]        r_sel;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_if_rdata, r_mem_rdata;

  logic              w_launch, w_launch_mem, w_done, w_busy, w_timeout;
  logic              w_mux_we;
  logic [3:0]        w_mux_sel;
  logic [ADDR_W-1:0] w_mux_addr;
  logic [DATA_W-1:0] w_mux_wdata, w_capture;
  logic              w_unused_stall;

  bus_port_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mux (
    .i_sel_mem  (w_launch_mem),
    .i_if_addr  (bus.if_addr),
    .i_mem_we   (bus.mem_we),
    .i_mem_sel  (bus.mem_sel),
    .i_mem_addr (bus.mem_addr),
    .i_mem_wdata(bus.mem_wdata),
    .o_we       (w_mux_we),
    .o_sel      (w_mux_sel),
    .o_addr     (w_mux_addr),
    .o_wdata    (w_mux_wdata)
  );

  assign w_busy = (r_state == S_IF_BUSY) || (r_state == S_MEM_BUSY);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_launch     = 1'b0;
    w_launch_mem = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!bus.flush && (bus.mem_ce || bus.if_ce)) begin
          w_launch     = 1'b1;
          w_launch_mem = bus.mem_ce;
          w_next       = bus.mem_ce ? S_MEM_BUSY : S_IF_BUSY;
        end
      end
      S_IF_BUSY, S_MEM_BUSY: begin
        if (bus.bus_ack_i || w_timeout) begin
          w_done = 1'b1;
          if (r_discard)                 w_next = S_IDLE;
          else if (r_state == S_IF_BUSY) w_next = S_IF_HOLD;
          else                           w_next = S_MEM_HOLD;
        end
      end
      S_IF_HOLD:  if (!bus.stall[STALL_IF]  || bus.flush) w_next = S_IDLE;
      S_MEM_HOLD: if (!bus.stall[STALL_MEM] || bus.flush) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  assign w_capture = w_timeout ? DATA_W'(ZeroWord) : bus.bus_rdata_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= 4'h0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_discard   <= 1'b0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
    end else begin
      if (w_launch) begin
        r_cyc   <= 1'b1;
        r_we    <= w_mux_we;
        r_sel   <= w_mux_sel;
        r_addr  <= w_mux_addr;
        r_wdata <= w_mux_wdata;
      end else if (w_done) begin
        r_cyc <= 1'b0;
        r_we  <= 1'b0;
        r_sel <= 4'h0;
      end
      // A flushed transaction still runs to completion; only its result is dropped.
      if (w_done)                r_discard <= 1'b0;
      else if (w_busy && bus.flush) r_discard <= 1'b1;
      if (w_done && !r_discard) begin
        if (r_state == S_IF_BUSY)      r_if_rdata  <= w_capture;
        else if (!r_we || w_timeout)   r_mem_rdata <= w_capture;
      end
    end
  end

`ifdef BUS_TIMEOUT_EN
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] r_wdog;
  logic       r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdog <= 8'd0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_timeout;
      if (w_launch)    r_wdog <= 8'd0;
      else if (w_busy) r_wdog <= r_wdog + 8'd1;
    end
  end

  assign w_timeout     = w_busy && !bus.bus_ack_i && (r_wdog == WDOG_LAST);
  assign bus.bus_err_o = r_err;
`else
  assign w_timeout     = 1'b0;
  assign bus.bus_err_o = 1'b0;
`endif

  assign bus.bus_cyc_o    = r_cyc;
  assign bus.bus_we_o     = r_we;
  assign bus.bus_sel_o    = r_sel;
  assign bus.bus_addr_o   = r_addr;
  assign bus.bus_wdata_o  = r_wdata;
  assign bus.if_rdata     = r_if_rdata;
  assign bus.mem_rdata    = r_mem_rdata;
  assign bus.stallreq_pc  = port_stallreq(bus.if_ce,  r_state == S_IF_HOLD);
  assign bus.stallreq_mem = port_stallreq(bus.mem_ce, r_state == S_MEM_HOLD);
  assign bus.dbg_state    = r_state;

  assign w_unused_stall = ^{bus.stall[5], bus.stall[3:2], bus.stall[0]};

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed self-checking bench for mem_bus_ctrl; the watchdog case runs only
// when BUS_TIMEOUT_EN is defined (DUT built with TIMEOUT_CYC=4).
module tb_mem_bus_ctrl;
  import mem_bus_ctrl_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  logic [31:0] exp_q[$];

  mem_bus_ctrl_if #(.ADDR_W(32), .DATA_W(32)) b ();

  mem_bus_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(b)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL sim_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_state(input string tag, input state_t exp);
    chk(tag, 32'(b.dbg_state), 32'(exp));
  endtask

  task automatic ack_with(input logic [31:0] data);
    b.bus_ack_i   = 1'b1;
    b.bus_rdata_i = data;
  endtask

  task automatic ack_clear();
    b.bus_ack_i   = 1'b0;
    b.bus_rdata_i = 32'h0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    b.stall = 6'b0; b.flush = 1'b0;
    b.if_ce = 1'b0; b.if_addr = 32'h0;
    b.mem_ce = 1'b0; b.mem_we = 1'b0; b.mem_sel = 4'h0;
    b.mem_addr = 32'h0; b.mem_wdata = 32'h0;
    b.bus_rdata_i = 32'h0; b.bus_ack_i = 1'b0;
    repeat (3) tick();

    // Reset state
    chk_state("rst_state", S_IDLE);
    chk("rst_cyc", 32'(b.bus_cyc_o), 32'd0);
    chk("rst_we", 32'(b.bus_we_o), 32'd0);
    chk("rst_sel", 32'(b.bus_sel_o), 32'd0);
    chk("rst_addr", b.bus_addr_o, 32'h0);
    chk("rst_if_rdata", b.if_rdata, 32'h0);
    chk("rst_mem_rdata", b.mem_rdata, 32'h0);
    chk("rst_err", 32'(b.bus_err_o), 32'd0);
    rst = 1'b0;
    tick();

    // Fetch acked on the second busy cycle
    b.if_ce = 1'b1; b.if_addr = 32'h8000_0000;
    #1 chk("t1_spc_idle", 32'(b.stallreq_pc), 32'd1);
    tick();
    chk_state("t1_busy", S_IF_BUSY);
    chk("t1_cyc1", 32'(b.bus_cyc_o), 32'd1);
    chk("t1_addr", b.bus_addr_o, 32'h8000_0000);
    chk("t1_we", 32'(b.bus_we_o), 32'd0);
    chk("t1_sel", 32'(b.bus_sel_o), 32'hF);
    tick();
    chk("t1_cyc2", 32'(b.bus_cyc_o), 32'd1);
    ack_with(32'h3C01_0001);
    exp_q.push_back(32'h3C01_0001);
    tick();
    ack_clear();
    chk_state("t1_hold", S_IF_HOLD);
    chk("t1_cyc_drop", 32'(b.bus_cyc_o), 32'd0);
    chk("t1_spc_low", 32'(b.stallreq_pc), 32'd0);
    chk("t1_if_rdata", b.if_rdata, exp_q.pop_front());
    b.if_ce = 1'b0;
    tick();
    chk_state("t1_idle", S_IDLE);

    // Simultaneous requests: MEM wins, fetch follows
    b.if_ce = 1'b1; b.if_addr = 32'h8000_0004;
    b.mem_ce = 1'b1; b.mem_we = 1'b0; b.mem_sel = 4'hF; b.mem_addr = 32'h8000_1000;
    tick();
    chk_state("t2_mem_first", S_MEM_BUSY);
    chk("t2_addr_mem", b.bus_addr_o, 32'h8000_1000);
    chk("t2_spc_busy", 32'(b.stallreq_pc), 32'd1);
    chk("t2_smem_busy", 32'(b.stallreq_mem), 32'd1);
    ack_with(32'h1234_5678);
    exp_q.push_back(32'h1234_5678);
    tick();
    ack_clear();
    chk_state("t2_mem_hold", S_MEM_HOLD);
    chk("t2_mem_rdata", b.mem_rdata, exp_q.pop_front());
    chk("t2_smem_low", 32'(b.stallreq_mem), 32'd0);
    chk("t2_spc_hold", 32'(b.stallreq_pc), 32'd1);
    b.mem_ce = 1'b0;
    tick();
    chk_state("t2_gap_idle", S_IDLE);
    chk("t2_gap_cyc", 32'(b.bus_cyc_o), 32'd0);
    chk("t2_spc_idle", 32'(b.stallreq_pc), 32'd1);
    tick();
    chk_state("t2_if_busy", S_IF_BUSY);
    chk("t2_addr_if", b.bus_addr_o, 32'h8000_0004);
    ack_with(32'hAABB_CCDD);
    exp_q.push_back(32'hAABB_CCDD);
    tick();
    ack_clear();
    chk("t2_if_rdata", b.if_rdata, exp_q.pop_front());
    b.if_ce = 1'b0;
    tick();

    // Load completed while MEM is held by the pipeline
    b.stall = 6'b01_0000;
    b.mem_ce = 1'b1; b.mem_we = 1'b0; b.mem_sel = 4'hF; b.mem_addr = 32'h8000_2000;
    tick();
    ack_with(32'hDEAD_BEEF);
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i == 1) ack_with(32'h0BAD_0BAD);
      else        ack_clear();
      chk_state("t3_hold_state", S_MEM_HOLD);
      chk("t3_hold_rdata", b.mem_rdata, 32'hDEAD_BEEF);
      chk("t3_hold_smem", 32'(b.stallreq_mem), 32'd0);
      chk("t3_hold_cyc", 32'(b.bus_cyc_o), 32'd0);
      tick();
    end
    ack_clear();
    chk("t3_stray_ack", b.mem_rdata, 32'hDEAD_BEEF);
    b.stall = 6'b0; b.mem_ce = 1'b0;
    tick();
    chk_state("t3_release", S_IDLE);

    // Flush in IDLE issues nothing; flush mid-fetch discards the result
    b.if_ce = 1'b1; b.if_addr = 32'h8000_0100; b.flush = 1'b1;
    tick();
    chk_state("t4_flush_idle", S_IDLE);
    chk("t4_flush_cyc", 32'(b.bus_cyc_o), 32'd0);
    b.flush = 1'b0;
    tick();
    chk_state("t4_busy", S_IF_BUSY);
    b.flush = 1'b1;
    tick();
    b.flush = 1'b0;
    chk("t4_cyc_kept", 32'(b.bus_cyc_o), 32'd1);
    tick();
    ack_with(32'h1111_1111);
    tick();
    ack_clear();
    chk_state("t4_discard_idle", S_IDLE);
    chk("t4_if_rdata_kept", b.if_rdata, 32'hAABB_CCDD);
    chk("t4_cyc_done", 32'(b.bus_cyc_o), 32'd0);
    b.if_addr = 32'h8000_0180;
    tick();
    chk_state("t4_refetch", S_IF_BUSY);
    chk("t4_refetch_addr", b.bus_addr_o, 32'h8000_0180);
    ack_with(32'h2222_2222);
    tick();
    ack_clear();
    chk_state("t4_refetch_hold", S_IF_HOLD);
    chk("t4_refetch_rdata", b.if_rdata, 32'h2222_2222);
    b.if_ce = 1'b0;
    tick();

    // Store: write strobes held until ack, load data untouched
    b.mem_ce = 1'b1; b.mem_we = 1'b1; b.mem_sel = 4'b0011;
    b.mem_addr = 32'h8000_3000; b.mem_wdata = 32'h0000_ABCD;
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("t5_we", 32'(b.bus_we_o), 32'd1);
      chk("t5_sel", 32'(b.bus_sel_o), 32'h3);
      chk("t5_wdata", b.bus_wdata_o, 32'h0000_ABCD);
      chk("t5_addr", b.bus_addr_o, 32'h8000_3000);
      if (i == 1) ack_with(32'h5555_5555);
      tick();
    end
    ack_clear();
    chk_state("t5_hold", S_MEM_HOLD);
    chk("t5_mem_rdata", b.mem_rdata, 32'hDEAD_BEEF);
    chk("t5_we_drop", 32'(b.bus_we_o), 32'd0);
    chk("t5_sel_drop", 32'(b.bus_sel_o), 32'd0);
    b.mem_ce = 1'b0; b.mem_we = 1'b0;
    tick();
    chk_state("t5_idle", S_IDLE);

    // Flush releases a held fetch even while IF is stalled
    b.stall = 6'b00_0010;
    b.if_ce = 1'b1; b.if_addr = 32'h8000_0200;
    tick();
    ack_with(32'h0123_4567);
    tick();
    ack_clear();
    tick();
    chk_state("t6_held", S_IF_HOLD);
    chk("t6_rdata", b.if_rdata, 32'h0123_4567);
    b.flush = 1'b1;
    tick();
    b.flush = 1'b0; b.if_ce = 1'b0; b.stall = 6'b0;
    chk_state("t6_flush_exit", S_IDLE);

    // Reset in the middle of a bus cycle
    b.mem_ce = 1'b1; b.mem_addr = 32'h8000_4000;
    tick();
    chk("t7_cyc_before", 32'(b.bus_cyc_o), 32'd1);
    rst = 1'b1;
    tick();
    chk_state("t7_state", S_IDLE);
    chk("t7_cyc", 32'(b.bus_cyc_o), 32'd0);
    chk("t7_if_rdata", b.if_rdata, 32'h0);
    chk("t7_mem_rdata", b.mem_rdata, 32'h0);
    rst = 1'b0; b.mem_ce = 1'b0;
    tick();

`ifdef BUS_TIMEOUT_EN
    // Watchdog: no ack, cycle abandoned after four busy cycles
    b.if_ce = 1'b1; b.if_addr = 32'h8000_0300;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("t8_cyc_busy", 32'(b.bus_cyc_o), 32'd1);
      chk("t8_err_quiet", 32'(b.bus_err_o), 32'd0);
      tick();
    end
    chk("t8_cyc_drop", 32'(b.bus_cyc_o), 32'd0);
    chk("t8_err_pulse", 32'(b.bus_err_o), 32'd1);
    chk_state("t8_hold", S_IF_HOLD);
    chk("t8_if_rdata", b.if_rdata, 32'h0);
    chk("t8_spc_release", 32'(b.stallreq_pc), 32'd0);
    b.if_ce = 1'b0;
    tick();
    chk("t8_err_end", 32'(b.bus_err_o), 32'd0);
    chk_state("t8_idle", S_IDLE);
`else
    chk("t8_err_tied", 32'(b.bus_err_o), 32'd0);
`endif

    // Final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
